mem_wb_stage: RTL
=================

// Module: mem_wb_stage
// PURPOSE
//  Memory stage plus MEM/WB pipeline register. It consumes the EX/MEM register outputs and runs loads, stores and RET pops
//  against a handshaked data memory. It stalls upstream while an access is outstanding, drives OUT_PORT, and delivers
//  write-back data, destination and return PC to the WB stage. An access timeout raises a sticky error.
// PARAMETERS
//  DATA_W    8   data/address width
//  MAX_WAIT  15  max ACCESS cycles without dmem_ack before timeout (>=1)
// PORTS
//  clk              in   1       clock, rising edge
//  reset            in   1       synchronous, active-high
//  wr_en_regf_M     in   1       instr writes register file
//  wr_en_dmem_M     in   1       store
//  rd_en_M          in   1       load / stack pop
//  out_port_sel_M   in   1       instr writes OUT_PORT
//  is_ret_M         in   1       RET: popped byte is return PC
//  mux_rdata_sel_M  in   2       WB source: 00 alu_out_M, 01 dmem_rdata, 10 IN_PORT_M, 11 mem_wd_M
//  alu_out_M        in   DATA_W  ALU result
//  rd_M             in   2       destination register
//  IN_PORT_M        in   DATA_W  sampled input port
//  mem_addr_M       in   DATA_W  memory address
//  mem_wd_M         in   DATA_W  memory write data
//  flush_M          in   1       kill instruction currently in MEM
//  dmem_req         out  1       access request, held until ack
//  dmem_we          out  1       1=write, 0=read
//  dmem_addr        out  DATA_W  access address
//  dmem_wdata       out  DATA_W  write data
//  dmem_rdata       in   DATA_W  read data, valid with dmem_ack
//  dmem_ack         in   1       access complete (1-cycle pulse)
//  stall_M          out  1       comb; freeze PC/IF/ID/EX/EX-MEM regs
//  wr_en_regf_W     out  1       WB register write enable
//  rd_W             out  2       WB destination
//  wb_data_W        out  DATA_W  WB data
//  ret_valid_W      out  1       1-cycle pulse: ret_pc_W valid
//  ret_pc_W         out  DATA_W  popped return PC
//  OUT_PORT         out  DATA_W  output port register
//  mem_err          out  1       sticky timeout flag
// BEHAVIOUR
//  Reset: state=IDLE, wait_cnt=0, kill=0; every output 0 (dmem_* 0, stall_M 0, OUT_PORT 0, mem_err 0).
//   Reset mid-ACCESS drops dmem_req the next cycle, and a late ack is ignored.
//  mem_op = rd_en_M | wr_en_dmem_M. If both are set, the store takes priority (dmem_we=1).
//  FSM IDLE: if mem_op, latch addr/we/wdata into dmem_* regs, set dmem_req, go ACCESS, and WB gets a bubble.
//   If ~mem_op, commit this cycle (1-cycle latency).
//  FSM ACCESS: dmem_req/addr/we/wdata stay stable. If dmem_ack, commit using dmem_rdata, drop dmem_req, go IDLE.
//   Else wait_cnt++. If this is the MAX_WAIT-th cycle without ack: mem_err<=1, bubble, drop dmem_req, go IDLE.
//   Ack in the timeout cycle: the ack wins, so no error is raised.
//  stall_M = (IDLE & mem_op) | (ACCESS & ~dmem_ack & ~timeout). It deasserts in the commit cycle so EX/MEM advances.
//  Commit (next edge):
//   wr_en_regf_W<=wr_en_regf_M; rd_W<=rd_M; wb_data_W<=mux(mux_rdata_sel_M).
//   OUT_PORT<=alu_out_M if out_port_sel_M, else hold.
//   ret_valid_W<=is_ret_M; ret_pc_W<=dmem_rdata.
//  Bubble: wr_en_regf_W<=0, ret_valid_W<=0; rd_W, wb_data_W and OUT_PORT hold.
//  Flush: flush_M in IDLE turns the cycle into a bubble with no access issued.
//   flush_M in ACCESS sets kill. The access still completes (a store is not aborted), and on ack the result is discarded as a bubble.
//   kill clears on leaving ACCESS.
//  mux sel 01 on a non-load returns the last latched dmem_rdata (don't-care, not checked).
//  mem_err clears only on reset.
// TESTING
//  ALU instr: alu_out_M=8'h3C, rd_M=2, sel=00, wr_en_regf_M=1 -> next cycle wr_en_regf_W=1, rd_W=2, wb_data_W=8'h3C, stall_M never 1.
//  Load addr 8'h10, ack after 3 cycles with rdata 8'hA5 -> stall_M high 4 cycles, dmem_addr=8'h10 stable, wb_data_W=8'hA5, rd_W latched.
//  Store addr 8'h20 data 8'h77, ack next cycle -> dmem_we=1, dmem_wdata=8'h77, wr_en_regf_W=0.
//   Back-to-back ALU instr commits the cycle after.
//  RET pop, rdata 8'h42 -> ret_valid_W pulses exactly 1 cycle with ret_pc_W=8'h42.
//   flush_M mid-ACCESS on a RET -> ack consumed, ret_valid_W stays 0.
//  No ack for 15 cycles -> mem_err=1 at cycle 15, stall_M drops, dmem_req drops.
//   Ack arriving at cycle 15 -> no error, normal commit.
//  OUT instr alu_out_M=8'h9E -> OUT_PORT=8'h9E and held.
//   reset asserted mid-ACCESS -> all outputs 0 next cycle, later ack ignored.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: issues loads, stores and RET pops to a
// handshaked data memory, stalls upstream while an access is in flight, and feeds WB.
module mem_wb_stage #(
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_regf_M,
  input  logic              wr_en_dmem_M,
  input  logic              rd_en_M,
  input  logic              out_port_sel_M,
  input  logic              is_ret_M,
  input  logic [1:0]        mux_rdata_sel_M,
  input  logic [DATA_W-1:0] alu_out_M,
  input  logic [1:0]        rd_M,
  input  logic [DATA_W-1:0] IN_PORT_M,
  input  logic [DATA_W-1:0] mem_addr_M,
  input  logic [DATA_W-1:0] mem_wd_M,
  input  logic              flush_M,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              stall_M,
  output logic              wr_en_regf_W,
  output logic [1:0]        rd_W,
  output logic [DATA_W-1:0] wb_data_W,
  output logic              ret_valid_W,
  output logic [DATA_W-1:0] ret_pc_W,
  output logic [DATA_W-1:0] OUT_PORT,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   wait_cnt;
  logic               kill;
  logic [DATA_W-1:0]  rdata_q;
  logic               mem_op;
  logic               issue;
  logic               commit;
  logic               timeout;
  logic [DATA_W-1:0]  wb_mux;

  assign mem_op = rd_en_M | wr_en_dmem_M;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    commit   = 1'b0;
    timeout  = 1'b0;
    case (state)
      IDLE: begin
        if (flush_M) begin
          // killed instruction: bubble, nothing issued
        end else if (mem_op) begin
          issue    = 1'b1;
          state_nx = ACCESS;
        end else begin
          commit = 1'b1;
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_nx = IDLE;
          commit   = ~(kill | flush_M);
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          timeout  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign stall_M = ~reset & (((state == IDLE) & mem_op & ~flush_M) |
                             ((state == ACCESS) & ~dmem_ack & ~timeout));

  // Loads commit straight from the memory bus; elsewhere sel 01 sees the last read.
  always_comb begin
    wb_mux = alu_out_M;
    case (mux_rdata_sel_M)
      2'b00: wb_mux = alu_out_M;
      2'b01: wb_mux = (state == ACCESS) ? dmem_rdata : rdata_q;
      2'b10: wb_mux = IN_PORT_M;
      2'b11: wb_mux = mem_wd_M;
      default: wb_mux = alu_out_M;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      kill         <= 1'b0;
      rdata_q      <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      wr_en_regf_W <= 1'b0;
      rd_W         <= '0;
      wb_data_W    <= '0;
      ret_valid_W  <= 1'b0;
      ret_pc_W     <= '0;
      OUT_PORT     <= '0;
      mem_err      <= 1'b0;
    end else begin
      state <= state_nx;

      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= wr_en_dmem_M;
        dmem_addr  <= mem_addr_M;
        dmem_wdata <= mem_wd_M;
        wait_cnt   <= '0;
      end else if (state == ACCESS) begin
        if (dmem_ack || timeout) dmem_req <= 1'b0;
        else                     wait_cnt <= wait_cnt + 1'b1;
      end

      // kill survives only while the access it belongs to is still open
      kill <= (state == ACCESS) && (state_nx == ACCESS) && (kill || flush_M);

      if (timeout) mem_err <= 1'b1;
      if (state == ACCESS && dmem_ack) rdata_q <= dmem_rdata;

      if (commit) begin
        wr_en_regf_W <= wr_en_regf_M;
        rd_W         <= rd_M;
        wb_data_W    <= wb_mux;
        ret_valid_W  <= is_ret_M;
        ret_pc_W     <= dmem_rdata;
        if (out_port_sel_M) OUT_PORT <= alu_out_M;
      end else begin
        wr_en_regf_W <= 1'b0;
        ret_valid_W  <= 1'b0;
      end
    end
  end

endmodule
